// File: rtl/div_operand_sequencer.sv
// Operand/result sequencer in front of the iterative signed divider, with a per-operation cycle timeout.
// Optional DIVZERO_BYPASS_EN: zero divisors skip the divider and return all-ones with out_dz set.
module div_operand_sequencer #(
    parameter int unsigned DD_W = 32,
    parameter int unsigned DV_W = 16,
    parameter int unsigned Q_W  = 16,
    parameter int unsigned TMO  = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DD_W-1:0] in_dd,
    input  logic [DV_W-1:0] in_dv,
    output logic [DD_W-1:0] div_dd,
    output logic [DV_W-1:0] div_dv,
    output logic            div_go,
    input  logic            div_done,
    input  logic [Q_W-1:0]  div_q,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Q_W-1:0]  out_q,
    output logic            out_dz,
    output logic            out_tmo,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_BUSY   = 3'd2,
        ST_RESULT = 3'd3
`ifdef DIVZERO_BYPASS_EN
        ,
        ST_BYPASS = 3'd4
`endif
    } state_t;

    localparam logic [15:0] TMO_C = 16'(TMO);

    state_t          r_state, w_state_nxt;
    logic            r_go, w_go_nxt;
    logic [Q_W-1:0]  r_q, w_q_nxt;
    logic            r_dz, w_dz_nxt;
    logic            r_tmo, w_tmo_nxt;
    logic [DD_W-1:0] r_dd, w_dd_nxt;
    logic [DV_W-1:0] r_dv, w_dv_nxt;
    logic [15:0]     r_cnt, w_cnt_nxt;
    logic [15:0]     w_cnt_inc;
    logic            w_expired;

    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_expired = (w_cnt_inc == TMO_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go_nxt    = r_go;
        w_q_nxt     = r_q;
        w_dz_nxt    = r_dz;
        w_tmo_nxt   = r_tmo;
        w_dd_nxt    = r_dd;
        w_dv_nxt    = r_dv;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_dd_nxt  = in_dd;
                    w_dv_nxt  = in_dv;
                    w_dz_nxt  = 1'b0;
                    w_tmo_nxt = 1'b0;
                    w_cnt_nxt = '0;
`ifdef DIVZERO_BYPASS_EN
                    if (in_dv == '0) begin
                        w_state_nxt = ST_BYPASS;
                    end else begin
                        w_state_nxt = ST_LAUNCH;
                        w_go_nxt    = 1'b1;
                    end
`else
                    w_state_nxt = ST_LAUNCH;
                    w_go_nxt    = 1'b1;
`endif
                end
            end
            ST_LAUNCH: begin
                w_cnt_nxt = w_cnt_inc;
                // Timeout outranks a same-cycle done transition.
                if (w_expired) begin
                    w_go_nxt    = 1'b0;
                    w_q_nxt     = '0;
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = ST_RESULT;
                end else if (!div_done) begin
                    w_go_nxt    = 1'b0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_expired) begin
                    w_go_nxt    = 1'b0;
                    w_q_nxt     = '0;
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = ST_RESULT;
                end else if (div_done) begin
                    w_q_nxt     = div_q;
                    w_state_nxt = ST_RESULT;
                end
            end
`ifdef DIVZERO_BYPASS_EN
            ST_BYPASS: begin
                w_q_nxt     = '1;
                w_dz_nxt    = 1'b1;
                w_state_nxt = ST_RESULT;
            end
`endif
            ST_RESULT: begin
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_go_nxt    = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_go  <= 1'b0;
            r_q   <= '0;
            r_dz  <= 1'b0;
            r_tmo <= 1'b0;
            r_dd  <= '0;
            r_dv  <= '0;
            r_cnt <= '0;
        end else begin
            r_go  <= w_go_nxt;
            r_q   <= w_q_nxt;
            r_dz  <= w_dz_nxt;
            r_tmo <= w_tmo_nxt;
            r_dd  <= w_dd_nxt;
            r_dv  <= w_dv_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_RESULT);
    assign div_dd    = r_dd;
    assign div_dv    = r_dv;
    assign div_go    = r_go;
    assign out_q     = r_q;
    assign out_dz    = r_dz;
    assign out_tmo   = r_tmo;
    assign state     = r_state;

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Directed bench for div_operand_sequencer with a behavioural 3-cycle divider model and TMO=10.
module tb_div_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_dd = '0;
    logic [15:0] in_dv = '0;
    logic [31:0] div_dd;
    logic [15:0] div_dv;
    logic        div_go;
    logic        div_done;
    logic [15:0] div_q;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_q;
    logic        out_dz;
    logic        out_tmo;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_operand_sequencer #(.DD_W(32), .DV_W(16), .Q_W(16), .TMO(10)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_dd(in_dd), .in_dv(in_dv),
        .div_dd(div_dd), .div_dv(div_dv), .div_go(div_go),
        .div_done(div_done), .div_q(div_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_dz(out_dz), .out_tmo(out_tmo), .state(state)
    );

    // Divider model: starts on go while idle, done low for 3 cycles, then presents the quotient.
    logic               stuck = 1'b0;
    logic               m_done;
    logic [1:0]         m_cnt;
    logic signed [31:0] m_a;
    logic signed [31:0] m_b;
    logic signed [31:0] m_res;
    logic [15:0]        m_q;

    assign m_res    = (m_b == 0) ? 32'sh00007A5A : (m_a / m_b);
    assign div_done = m_done;
    assign div_q    = m_q;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_done <= 1'b1;
            m_cnt  <= '0;
            m_a    <= '0;
            m_b    <= '0;
            m_q    <= '0;
        end else if (m_done && div_go && !stuck) begin
            m_done <= 1'b0;
            m_cnt  <= 2'd3;
            m_a    <= $signed(div_dd);
            m_b    <= 32'($signed(div_dv));
        end else if (!m_done) begin
            if (m_cnt == 2'd1) begin
                m_done <= 1'b1;
                m_q    <= m_res[15:0];
            end else begin
                m_cnt <= m_cnt - 2'd1;
            end
        end
    end

    // Called at a negedge; returns at the first negedge after the accepting edge.
    task automatic accept(input logic [31:0] dd, input logic [15:0] dv, input bit hold, output bit ok);
        in_dd    = dd;
        in_dv    = dv;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (div_go !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_go_valid got %b%b exp 00", div_go, out_valid); end
        checks++; if ({out_q, out_dz, out_tmo} !== 18'd0) begin errors++; $display("FAIL rst_result got %h/%b/%b exp 0/0/0", out_q, out_dz, out_tmo); end
        checks++; if (div_dd !== 32'd0 || div_dv !== 16'd0) begin errors++; $display("FAIL rst_operands got %h/%h exp 0/0", div_dd, div_dv); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok; int n;
        out_ready = 1'b1;
        checks++; if (div_go !== 1'b0) begin errors++; $display("FAIL basic_go_pre got %b exp 0", div_go); end
        accept(32'd100, 16'd7, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_accept got timeout exp in_ready"); end
        checks++; if (div_go !== 1'b1 || state !== 3'd1) begin errors++; $display("FAIL basic_launch got go=%b st=%0d exp go=1 st=1", div_go, state); end
        checks++; if (div_dd !== 32'd100 || div_dv !== 16'd7) begin errors++; $display("FAIL basic_operands got %0d/%0d exp 100/7", div_dd, div_dv); end
        @(negedge clk);
        checks++; if (div_go !== 1'b1) begin errors++; $display("FAIL basic_go_hold got %b exp 1", div_go); end
        @(negedge clk);
        checks++; if (div_go !== 1'b0 || state !== 3'd2) begin errors++; $display("FAIL basic_go_fall got go=%b st=%0d exp go=0 st=2", div_go, state); end
        wait_result(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", n); end
        checks++; if (out_q !== 16'd14 || out_dz !== 1'b0 || out_tmo !== 1'b0) begin errors++; $display("FAIL basic_result got %h/%b/%b exp 000e/0/0", out_q, out_dz, out_tmo); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_excl got %b exp 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_drain got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back;
        bit ok; int n;
        out_ready = 1'b1;
        accept(-32'sd100, 16'd7, 1'b1, ok);
        in_dd = 32'd100;
        in_dv = -16'sd7;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_accept1 got timeout exp in_ready"); end
        wait_result(n);
        checks++; if (out_q !== 16'hFFF2) begin errors++; $display("FAIL b2b_q1 got %h exp fff2", out_q); end
        checks++; if (div_dd !== 32'hFFFFFF9C) begin errors++; $display("FAIL b2b_hold_dd got %h exp ffffff9c", div_dd); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL b2b_idle got r=%b st=%0d exp r=1 st=0", in_ready, state); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (state !== 3'd1 || div_dd !== 32'd100 || div_dv !== 16'hFFF9) begin errors++; $display("FAIL b2b_accept2 got st=%0d %h/%h exp st=1 00000064/fff9", state, div_dd, div_dv); end
        wait_result(n);
        checks++; if (out_q !== 16'hFFF2 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_q2 got %h v=%b exp fff2 v=1", out_q, out_valid); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit ok; int n; int bad;
        out_ready = 1'b0;
        accept(32'd50, -16'sd5, 1'b0, ok);
        wait_result(n);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_arrive got %b exp 1", out_valid); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== 16'hFFF6) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles exp 0", bad); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_divzero;
        bit ok; int n; int go_seen;
        out_ready = 1'b1;
        go_seen = 0;
        accept(32'd5, 16'd0, 1'b0, ok);
`ifdef DIVZERO_BYPASS_EN
        if (div_go === 1'b1) go_seen++;
        checks++; if (state !== 3'd4 || out_valid !== 1'b0) begin errors++; $display("FAIL dz_bypass got st=%0d v=%b exp st=4 v=0", state, out_valid); end
        @(negedge clk);
        if (div_go === 1'b1) go_seen++;
        checks++; if (out_valid !== 1'b1 || out_q !== 16'hFFFF || out_dz !== 1'b1) begin errors++; $display("FAIL dz_result got v=%b %h dz=%b exp v=1 ffff dz=1", out_valid, out_q, out_dz); end
        @(negedge clk);
        if (div_go === 1'b1) go_seen++;
        checks++; if (go_seen != 0) begin errors++; $display("FAIL dz_no_go got %0d go cycles exp 0", go_seen); end
`else
        checks++; if (div_go !== 1'b1) begin errors++; $display("FAIL dz_launch got %b exp 1", div_go); end
        wait_result(n);
        checks++; if (out_q !== 16'h7A5A || out_dz !== 1'b0) begin errors++; $display("FAIL dz_passthru got %h dz=%b exp 7a5a dz=0", out_q, out_dz); end
        @(negedge clk);
`endif
    endtask

    task automatic test_timeout;
        bit ok; int bad;
        out_ready = 1'b1;
        stuck = 1'b1;
        accept(32'd100, 16'd7, 1'b0, ok);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (div_go !== 1'b1 || out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tmo_wait got %0d bad cycles exp 0", bad); end
        checks++; if (out_valid !== 1'b1 || out_tmo !== 1'b1) begin errors++; $display("FAIL tmo_abort got v=%b tmo=%b exp v=1 tmo=1", out_valid, out_tmo); end
        checks++; if (out_q !== 16'd0 || div_go !== 1'b0 || out_dz !== 1'b0) begin errors++; $display("FAIL tmo_result got %h go=%b dz=%b exp 0000 go=0 dz=0", out_q, div_go, out_dz); end
        @(negedge clk);
        stuck = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tmo_drain got %b exp 1", in_ready); end
    endtask

    task automatic test_reset_midop;
        bit ok; int n;
        out_ready = 1'b1;
        accept(32'd100, 16'd7, 1'b0, ok);
        repeat (2) @(negedge clk);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL rmid_busy got %0d exp 2", state); end
        #2 reset = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || div_go !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_async got st=%0d go=%b r=%b exp st=0 go=0 r=1", state, div_go, in_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        accept(32'd9, 16'd3, 1'b0, ok);
        wait_result(n);
        checks++; if (out_valid !== 1'b1 || out_q !== 16'd3 || out_tmo !== 1'b0) begin errors++; $display("FAIL rmid_next got v=%b %h tmo=%b exp v=1 0003 tmo=0", out_valid, out_q, out_tmo); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_divzero();
        test_timeout();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
